// File: rtl/muldiv_unit_if.sv
// Execute-stage control <-> multiply/divide unit bundle.
// master drives start/op/a/b/mthi/mtlo/wdata; slave returns hi/lo/busy/done.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b, mthi, mtlo, wdata,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo, wdata,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Ports: clk, rst_n (async low), bus (slave: start/op/a/b/mt*/wdata -> hi/lo/busy/done).
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam int W = WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t           state;
   state_t           state_n;
   logic             load;
   logic             step;
   logic             fin;

   logic [CNT_W-1:0] cnt;
   logic             div_q;
   logic             neg_q;
   logic             rneg_q;
   logic             bzero_q;
   logic [W-1:0]     opnd_q;
   logic [2*W-1:0]   acc_q;
   logic [W-1:0]     hi_q;
   logic [W-1:0]     lo_q;
   logic             busy_q;
   logic             done_q;

   logic             sgn;
   logic [W-1:0]     mag_a;
   logic [W-1:0]     mag_b;

   logic [W:0]       mul_sum;
   logic [2*W-1:0]   mul_nxt;
   logic [W:0]       rem_sh;
   logic [W:0]       diff;
   logic [2*W-1:0]   div_nxt;

   logic [2*W-1:0]   prod;
   logic [W-1:0]     quot;
   logic [W-1:0]     rem;
   logic [W-1:0]     q_fix;
   logic [W-1:0]     r_fix;

   assign sgn   = ~bus.op[0];
   assign mag_a = (sgn && bus.a[W-1]) ? -bus.a : bus.a;
   assign mag_b = (sgn && bus.b[W-1]) ? -bus.b : bus.b;

   // Multiply: acc = {partial, multiplier}; add on lsb, shift right.
   assign mul_sum = {1'b0, acc_q[2*W-1:W]}
                  + {1'b0, (acc_q[0] ? opnd_q : '0)};
   assign mul_nxt = {mul_sum, acc_q[W-1:1]};

   // Divide: acc = {remainder, quotient}; restoring shift-subtract.
   assign rem_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
   assign diff    = rem_sh - {1'b0, opnd_q};
   assign div_nxt = diff[W]
                  ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                  : {diff[W-1:0], acc_q[W-2:0], 1'b1};

   assign prod  = neg_q ? -acc_q : acc_q;
   assign quot  = acc_q[W-1:0];
   assign rem   = acc_q[2*W-1:W];
   // b=0 leaves rem=|a| so sign fix restores original a; only lo needs forcing.
   assign q_fix = bzero_q ? '1 : (neg_q ? -quot : quot);
   assign r_fix = rneg_q ? -rem : rem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      fin     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) state_n = FIN;
         end
         FIN: begin
            fin     = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         bzero_q <= 1'b0;
         opnd_q  <= '0;
         acc_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         busy_q <= (state_n != IDLE);
         done_q <= fin;
         if (load) begin
            cnt     <= CNT_W'(W);
            div_q   <= bus.op[1];
            neg_q   <= sgn & (bus.a[W-1] ^ bus.b[W-1]);
            rneg_q  <= sgn & bus.a[W-1];
            bzero_q <= (bus.b == '0);
            opnd_q  <= bus.op[1] ? mag_b : mag_a;
            acc_q   <= {{W{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
         end
         if (step) begin
            cnt   <= cnt - CNT_W'(1);
            acc_q <= div_q ? div_nxt : mul_nxt;
         end
         if (fin) begin
            if (div_q) begin
               hi_q <= r_fix;
               lo_q <= q_fix;
            end else begin
               {hi_q, lo_q} <= prod;
            end
         end else if (state == IDLE) begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
         end
      end
   end

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Expected HI/LO pushed at start, popped and compared on done.
module tb_muldiv_unit;
   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   exp_t sb[$];

   muldiv_unit_if #(.WIDTH(32)) dut_if ();

   muldiv_unit #(
      .WIDTH(32),
      .CNT_W(6)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (dut_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [1:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      p;
      logic [63:0] u;
      int          sa;
      int          sbv;
      sa  = $signed(a);
      sbv = $signed(b);
      case (op)
         2'd0: begin
            p = longint'(sa) * longint'(sbv);
            u = p;
            e.hi = u[63:32];
            e.lo = u[31:0];
         end
         2'd1: begin
            u = {32'd0, a} * {32'd0, b};
            e.hi = u[63:32];
            e.lo = u[31:0];
         end
         2'd2: begin
            if (b == 32'd0) begin
               e.lo = 32'hFFFFFFFF;
               e.hi = a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               e.lo = 32'h80000000;
               e.hi = 32'd0;
            end else begin
               e.lo = sa / sbv;
               e.hi = sa % sbv;
            end
         end
         default: begin
            if (b == 32'd0) begin
               e.lo = 32'hFFFFFFFF;
               e.hi = a;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Caller is at a negedge; start is held across exactly one rising edge.
   task automatic issue(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
      dut_if.op    = op;
      dut_if.a     = a;
      dut_if.b     = b;
      dut_if.start = 1'b1;
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      dut_if.a     = $urandom;
      dut_if.b     = $urandom;
   endtask

   task automatic wait_done(output bit ok, output int bcnt);
      ok   = 1'b0;
      bcnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dut_if.busy) bcnt++;
         if (dut_if.done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      dut_if.start = 1'b0;
      dut_if.op    = 2'd0;
      dut_if.a     = '0;
      dut_if.b     = '0;
      dut_if.mthi  = 1'b0;
      dut_if.mtlo  = 1'b0;
      dut_if.wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_if.hi !== 32'd0) begin
         failures++;
         $display("FAIL reset_hi got=%h exp=0", dut_if.hi);
      end
      checks++;
      if (dut_if.lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_lo got=%h exp=0", dut_if.lo);
      end
      checks++;
      if (dut_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_busy got=%b exp=0", dut_if.busy);
      end
      checks++;
      if (dut_if.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_done got=%b exp=0", dut_if.done);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_multu_max();
      exp_t e;
      bit   ok;
      int   bc;
      e.hi = 32'hFFFFFFFE;
      e.lo = 32'h00000001;
      @(negedge clk);
      sb.push_back(e);
      issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(ok, bc);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL multu_max_timeout got=no_done exp=done");
      end else begin
         e = sb.pop_front();
         checks++;
         if (dut_if.hi !== e.hi) begin
            failures++;
            $display("FAIL multu_max_hi got=%h exp=%h", dut_if.hi, e.hi);
         end
         checks++;
         if (dut_if.lo !== e.lo) begin
            failures++;
            $display("FAIL multu_max_lo got=%h exp=%h", dut_if.lo, e.lo);
         end
         checks++;
         if (bc !== 33) begin
            failures++;
            $display("FAIL multu_busy_len got=%0d exp=33", bc);
         end
         @(negedge clk);
         checks++;
         if (dut_if.done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got=%b exp=0", dut_if.done);
         end
         repeat (3) @(negedge clk);
         checks++;
         if ({dut_if.hi, dut_if.lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL hold got=%h%h exp=%h%h",
                     dut_if.hi, dut_if.lo, e.hi, e.lo);
         end
      end
   endtask

   task automatic test_signed_ops();
      vec_t tbl[4];
      exp_t e;
      bit   ok;
      int   bc;
      tbl[0] = '{2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
      tbl[1] = '{2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[2] = '{2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF};
      tbl[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         e.hi = tbl[i].hi;
         e.lo = tbl[i].lo;
         sb.push_back(e);
         issue(tbl[i].op, tbl[i].a, tbl[i].b);
         wait_done(ok, bc);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL vec%0d_timeout got=no_done exp=done", i);
         end else begin
            e = sb.pop_front();
            checks++;
            if (dut_if.hi !== e.hi) begin
               failures++;
               $display("FAIL vec%0d_hi got=%h exp=%h", i, dut_if.hi, e.hi);
            end
            checks++;
            if (dut_if.lo !== e.lo) begin
               failures++;
               $display("FAIL vec%0d_lo got=%h exp=%h", i, dut_if.lo, e.lo);
            end
         end
      end
   endtask

   task automatic test_mt_with_start();
      exp_t e;
      bit   ok;
      int   bc;
      @(negedge clk);
      sb.push_back(model(2'd0, 32'd3, 32'hFFFFFFFE));
      dut_if.mthi  = 1'b1;
      dut_if.mtlo  = 1'b1;
      dut_if.wdata = 32'hA5A5_0F0F;
      issue(2'd0, 32'd3, 32'hFFFFFFFE);
      dut_if.mthi = 1'b0;
      dut_if.mtlo = 1'b0;
      checks++;
      if ({dut_if.hi, dut_if.lo} !== {32'hA5A5_0F0F, 32'hA5A5_0F0F}) begin
         failures++;
         $display("FAIL mt_both got=%h/%h exp=a5a50f0f/a5a50f0f",
                  dut_if.hi, dut_if.lo);
      end
      checks++;
      if (dut_if.busy !== 1'b1) begin
         failures++;
         $display("FAIL mt_start_busy got=%b exp=1", dut_if.busy);
      end
      wait_done(ok, bc);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL mt_op_timeout got=no_done exp=done");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({dut_if.hi, dut_if.lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL mt_op_result got=%h%h exp=%h%h",
                     dut_if.hi, dut_if.lo, e.hi, e.lo);
         end
      end
   endtask

   task automatic test_ignore_while_busy();
      exp_t e;
      bit   ok;
      int   bc;
      int   nd;
      e.hi = 32'd0;
      e.lo = 32'd30;
      @(negedge clk);
      sb.push_back(e);
      issue(2'd1, 32'd5, 32'd6);
      repeat (9) @(negedge clk);
      dut_if.op    = 2'd0;
      dut_if.a     = 32'd7;
      dut_if.b     = 32'd7;
      dut_if.mthi  = 1'b1;
      dut_if.wdata = 32'hDEAD_BEEF;
      dut_if.start = 1'b1;
      @(posedge clk);
      #1;
      dut_if.start = 1'b0;
      dut_if.mthi  = 1'b0;
      wait_done(ok, bc);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL busy_ign_timeout got=no_done exp=done");
      end else begin
         e = sb.pop_front();
         checks++;
         if (dut_if.hi !== e.hi) begin
            failures++;
            $display("FAIL busy_ign_hi got=%h exp=%h", dut_if.hi, e.hi);
         end
         checks++;
         if (dut_if.lo !== e.lo) begin
            failures++;
            $display("FAIL busy_ign_lo got=%h exp=%h", dut_if.lo, e.lo);
         end
      end
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut_if.done) nd++;
      end
      checks++;
      if (nd !== 0) begin
         failures++;
         $display("FAIL busy_ign_extra_done got=%0d exp=0", nd);
      end
   endtask

   task automatic test_reset_mid_op();
      int nd;
      @(negedge clk);
      issue(2'd1, 32'd5, 32'd6);
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({dut_if.hi, dut_if.lo} !== 64'd0) begin
         failures++;
         $display("FAIL midrst_hilo got=%h/%h exp=0/0", dut_if.hi, dut_if.lo);
      end
      checks++;
      if (dut_if.busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_busy got=%b exp=0", dut_if.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dut_if.done || dut_if.busy) nd++;
      end
      checks++;
      if (nd !== 0) begin
         failures++;
         $display("FAIL midrst_resume got=%0d exp=0", nd);
      end
      dut_if.mtlo  = 1'b1;
      dut_if.wdata = 32'h0000_1234;
      @(posedge clk);
      #1;
      dut_if.mtlo = 1'b0;
      checks++;
      if (dut_if.lo !== 32'h0000_1234) begin
         failures++;
         $display("FAIL mtlo got=%h exp=00001234", dut_if.lo);
      end
      checks++;
      if (dut_if.hi !== 32'd0) begin
         failures++;
         $display("FAIL mtlo_hi got=%h exp=0", dut_if.hi);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] edges[5];
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;
      bit          ok;
      int          bc;
      edges[0] = 32'h80000000;
      edges[1] = 32'hFFFFFFFF;
      edges[2] = 32'h7FFFFFFF;
      edges[3] = 32'd0;
      edges[4] = 32'd1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)]
                                          : $urandom;
         case ($urandom_range(0, 4))
            0:       b = 32'd0;
            1:       b = edges[$urandom_range(0, 4)];
            2:       b = 32'($urandom_range(1, 50));
            default: b = $urandom;
         endcase
         sb.push_back(model(op, a, b));
         issue(op, a, b);
         wait_done(ok, bc);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL b2b%0d_timeout got=no_done exp=done", i);
            break;
         end
         e = sb.pop_front();
         checks++;
         if ({dut_if.hi, dut_if.lo} !== {e.hi, e.lo}) begin
            failures++;
            $display("FAIL b2b%0d op=%0d a=%h b=%h got=%h%h exp=%h%h",
                     i, op, a, b, dut_if.hi, dut_if.lo, e.hi, e.lo);
         end
         checks++;
         if (bc !== 33) begin
            failures++;
            $display("FAIL b2b%0d_busy got=%0d exp=33", i, bc);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_multu_max();
      test_signed_ops();
      test_mt_with_start();
      test_ignore_while_busy();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
